// File: rtl/serializador_pkg.sv
// Shared definitions for the serial link blocks (deserializer, queue, serializer).
//   ser_state_t : serializer FSM states
//   WORD_W      : default word width in bits
package serializador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int unsigned WORD_W = 8;

endpackage

// File: rtl/serializador_if.sv
// Word-source / serial-sink bundle for the serializer.
//   master : word source + receiver side (drives word_in, word_valid_in, rx_ready_in)
//   slave  : serializer side (drives ack, serial data/strobe, status, word count)
interface serializador_if
  import serializador_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = 8
);

  logic [WIDTH-1:0] word_in;
  logic             word_valid_in;
  logic             word_ack_out;
  logic             rx_ready_in;
  logic             data_out;
  logic             write_out;
  logic             status_out;
  logic [CNT_W-1:0] words_sent_out;

  modport master (
    output word_in, word_valid_in, rx_ready_in,
    input  word_ack_out, data_out, write_out, status_out, words_sent_out
  );

  modport slave (
    input  word_in, word_valid_in, rx_ready_in,
    output word_ack_out, data_out, write_out, status_out, words_sent_out
  );

endinterface

// File: rtl/serializador.sv
// Parallel-to-serial transmitter (100 KHz domain).
// Captures a word from the source, acknowledges it with a one-cycle pulse,
// then shifts it out MSB-first with a per-bit write strobe, pausing while
// the receiver is not ready. One GAP cycle follows every word.
// Ports:
//   clk_100KHz : clock, rising edge
//   reset      : asynchronous, active-low
//   bus        : serializador_if.slave (word handshake, serial out, status, count)
module serializador
  import serializador_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk_100KHz,
  input logic           reset,
  serializador_if.slave bus
);

  // A one-bit word still needs a one-bit counter.
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             data_q, data_d;
  logic             write_q, write_d;
  logic [CNT_W-1:0] sent_q, sent_d;

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= 1'b0;
      write_q <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      write_q <= write_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    data_d  = data_q;
    write_d = 1'b0;
    sent_d  = sent_q;

    unique case (state_q)
      IDLE: begin
        if (bus.word_valid_in) begin
          shreg_d = bus.word_in;
          cnt_d   = '0;
          ack_d   = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Back-pressure holds data_out, shreg and cnt; only the strobe drops.
        if (bus.rx_ready_in) begin
          write_d = 1'b1;
          data_d  = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            sent_d  = sent_q + 1'b1;
            state_d = GAP;
          end
        end
      end

      GAP: begin
        data_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.word_ack_out   = ack_q;
  assign bus.data_out       = data_q;
  assign bus.write_out      = write_q;
  assign bus.words_sent_out = sent_q;
  assign bus.status_out     = (state_q != IDLE);

endmodule
